// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit engine.
// Frame length includes a parity bit only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int   DATA_W_DEF = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  localparam int START_BITS = 1;
  localparam int STOP_BITS  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif
  localparam int FRAME_BITS = START_BITS + DATA_W_DEF + PARITY_BITS + STOP_BITS;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time generator: counts 0..div and ticks on the last clock of each bit.
// The divisor is captured on load, so it only changes between frames.
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;

  assign tick = (cnt == div_q);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      div_q <= '0;
    end else if (load) begin
      cnt   <= '0;
      div_q <= div;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: pops bytes from the TX FIFO and serialises them LSB first.
// Define UART_TX_PARITY_EN to insert a parity bit between data and stop.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic              parity_odd,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              pop_out,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  tx_state_e         state;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic              baud_load;
  logic              tick;

`ifdef UART_TX_PARITY_EN
  logic par_q;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  assign baud_load = (state == LOAD);

  uart_baud_tick #(.DIV_W(DIV_W)) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .load (baud_load),
    .div  (baud_div),
    .tick (tick)
  );

  // Pop is decoded combinationally so the FIFO sees it in the IDLE clock itself;
  // gating with rst keeps it low while the engine is held in reset.
  assign pop_out = rst && (state == IDLE) && en && !fifo_empty;
  assign busy    = (state != IDLE);
  assign tx_done = (state == STOP) && tick;

  // NOTE: the shift register is a handful of flops, not a memory, so it is cleared by reset too.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      tx      <= IDLE_LEVEL;
      shreg   <= '0;
      bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (pop_out) state <= LOAD;
        end
        LOAD: begin
          shreg   <= fifo_dout;
          bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
          par_q   <= (^fifo_dout) ^ parity_odd;
`endif
          tx      <= ~IDLE_LEVEL;
          state   <= START;
        end
        START: begin
          if (tick) begin
            tx    <= shreg[0];
            shreg <= shreg >> 1;
            state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              tx    <= par_q;
              state <= PARITY;
`else
              tx    <= IDLE_LEVEL;
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            tx    <= IDLE_LEVEL;
            state <= STOP;
          end
        end
        STOP: begin
          if (tick) state <= IDLE;
        end
        default: begin
          tx    <= IDLE_LEVEL;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: table-driven frames plus burst, enable-drop,
// mid-frame reset and divisor-change sequences against a small FIFO model.
module tb_uart_tx_engine;
  import uart_pkg::*;

  localparam int DW    = DATA_W_DEF;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             parity_odd = 1'b0;
  logic [DIV_W-1:0] baud_div = '0;
  logic             fifo_empty;
  logic [DW-1:0]    fifo_dout = '0;
  logic             pop_out, tx, busy, tx_done;

  always #5 clk = ~clk;

  uart_tx_engine #(.DATA_W(DW), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .baud_div   (baud_div),
    .parity_odd (parity_odd),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .pop_out    (pop_out),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  // FIFO model: initial block owns the write side, this always block the read side.
  logic [DW-1:0] fifo_data [0:31];
  int wr_ptr = 0, rd_ptr = 0, pop_cnt = 0, bad_pop = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (pop_out) begin
      if (fifo_empty || busy) bad_pop <= bad_pop + 1;
      fifo_dout <= fifo_data[rd_ptr[4:0]];
      rd_ptr    <= rd_ptr + 1;
      pop_cnt   <= pop_cnt + 1;
    end
  end

  task automatic push(input logic [DW-1:0] b);
    fifo_data[wr_ptr[4:0]] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Expected serial frame, bit i = i-th bit on the line.
  function automatic logic [15:0] frame_of(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {5'b0, 1'b1, (^d) ^ parity_odd, d, 1'b0};
`else
    return {6'b0, 1'b1, d, 1'b0};
`endif
  endfunction

  // act: 1 = drop en, 2 = set baud_div to 7, applied at clock act_at of the frame.
  task automatic capture_frame(input int div, input int act_at, input int act,
                               output logic [15:0] bits, output int span, output int done_cnt,
                               output bit stable, output int wait_clks, output bit started);
    int total, b;
    total = FRAME_BITS * (div + 1);
    bits = '0; span = 0; done_cnt = 0; stable = 1'b1; wait_clks = 0; started = 1'b0;
    for (int w = 0; w < 400; w++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        started = 1'b1;
        break;
      end
      wait_clks++;
    end
    if (!started) return;
    for (int c = 0; c < total; c++) begin
      if (c > 0) @(negedge clk);
      if (c == act_at) begin
        if (act == 1) en = 1'b0;
        else if (act == 2) baud_div = 16'd7;
      end
      b = c / (div + 1);
      if (c % (div + 1) == 0) bits[b] = tx;
      else if (tx !== bits[b]) stable = 1'b0;
      if (busy !== 1'b1) stable = 1'b0;
      if (tx_done === 1'b1) begin
        done_cnt++;
        span = c + 1;
      end
    end
  endtask

  task automatic frame_checks(input string name, input int div, input logic [15:0] exp_bits,
                              input int act_at, input int act, output int wait_clks);
    logic [15:0] bits;
    int span, done_cnt;
    bit stable, started;
    capture_frame(div, act_at, act, bits, span, done_cnt, stable, wait_clks, started);
    check({name, "_started"}, 32'(started), 1);
    if (started) begin
      check({name, "_bits"}, 32'(bits), 32'(exp_bits));
      check({name, "_stable"}, 32'(stable), 1);
      check({name, "_span"}, span, FRAME_BITS * (div + 1));
      check({name, "_done_cnt"}, done_cnt, 1);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         div;
    logic       odd;
    logic [9:0] exp_frame;  // stop, data[7:0], start -- parity excluded
    logic       exp_par;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int wc, p0, done_seen;
    bit seen;
    logic [15:0] exp;

    vecs[0] = '{8'hA5, 3, 1'b0, 10'b1101001010, 1'b0};
    vecs[1] = '{8'h00, 0, 1'b0, 10'b1000000000, 1'b0};
    vecs[2] = '{8'hFF, 1, 1'b0, 10'b1111111110, 1'b0};
    vecs[3] = '{8'h3C, 2, 1'b0, 10'b1001111000, 1'b0};
    vecs[4] = '{8'h80, 4, 1'b0, 10'b1100000000, 1'b1};
    vecs[5] = '{8'hA5, 3, 1'b1, 10'b1101001010, 1'b1};

    // Reset state, with a byte waiting and en high.
    en = 1'b1;
    push(8'h69);
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_tx_done", 32'(tx_done), 0);
    check("rst_pop_out", 32'(pop_out), 0);
    check("rst_pop_cnt", pop_cnt, 0);
    rst = 1'b1;
    #1 check("rel_first_pop", 32'(pop_out), 1);
    frame_checks("rel_frame", 0, frame_of(8'h69), -1, 0, wc);
    @(negedge clk);
    check("rel_idle_busy", 32'(busy), 0);

    // Table-driven single frames.
    for (int i = 0; i < 6; i++) begin
      baud_div   = DIV_W'(vecs[i].div);
      parity_odd = vecs[i].odd;
`ifdef UART_TX_PARITY_EN
      exp = {5'b0, 1'b1, vecs[i].exp_par, vecs[i].exp_frame[8:0]};
`else
      exp = {6'b0, vecs[i].exp_frame};
`endif
      p0 = pop_cnt;
      push(vecs[i].data);
      frame_checks($sformatf("vec%0d", i), vecs[i].div, exp, -1, 0, wc);
      @(negedge clk);
      check($sformatf("vec%0d_idle_busy", i), 32'(busy), 0);
      check($sformatf("vec%0d_idle_done", i), 32'(tx_done), 0);
      check($sformatf("vec%0d_pops", i), pop_cnt - p0, 1);
    end
    parity_odd = 1'b0;

    // Burst of three bytes at baud_div=0.
    en = 1'b0;
    baud_div = '0;
    push(8'h11); push(8'h22); push(8'h33);
    p0 = pop_cnt;
    en = 1'b1;
    frame_checks("burst0", 0, frame_of(8'h11), -1, 0, wc);
    frame_checks("burst1", 0, frame_of(8'h22), -1, 0, wc);
    check("burst1_gap", wc, 2);
    frame_checks("burst2", 0, frame_of(8'h33), -1, 0, wc);
    check("burst2_gap", wc, 2);
    repeat (10) @(negedge clk);
    check("burst_empty", 32'(fifo_empty), 1);
    check("burst_pops", pop_cnt - p0, 3);
    check("burst_idle_tx", 32'(tx), 1);

    // en dropped during DATA of the first of two queued frames.
    en = 1'b0;
    baud_div = 16'd1;
    push(8'hAA); push(8'h55);
    p0 = pop_cnt;
    en = 1'b1;
    frame_checks("endrop0", 1, frame_of(8'hAA), 8, 1, wc);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) seen = 1'b1;
    end
    check("endrop_line_idle", 32'(seen), 0);
    check("endrop_held_pops", pop_cnt - p0, 1);
    en = 1'b1;
    frame_checks("endrop1", 1, frame_of(8'h55), -1, 0, wc);
    @(negedge clk);
    check("endrop_pops", pop_cnt - p0, 2);

    // Reset at data bit 4 of a frame.
    baud_div = 16'd3;
    p0 = pop_cnt;
    push(8'hC6);
    seen = 1'b0;
    for (int w = 0; w < 50 && !seen; w++) begin
      @(negedge clk);
      if (tx === 1'b0) seen = 1'b1;
    end
    check("mrst_start", 32'(seen), 1);
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mrst_tx", 32'(tx), 1);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_tx_done", 32'(tx_done), 0);
    push(8'h3B);
    done_seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (tx_done !== 1'b0) done_seen++;
    end
    check("mrst_no_done", done_seen, 0);
    rst = 1'b1;
    #1 check("mrst_first_pop", 32'(pop_out), 1);
    frame_checks("mrst_frame", 3, frame_of(8'h3B), -1, 0, wc);
    @(negedge clk);
    check("mrst_pops", pop_cnt - p0, 2);

    // Divisor raised from 3 to 7 in the middle of a frame.
    en = 1'b0;
    baud_div = 16'd3;
    push(8'hC3); push(8'h96);
    en = 1'b1;
    frame_checks("div_old", 3, frame_of(8'hC3), 10, 2, wc);
    frame_checks("div_new", 7, frame_of(8'h96), -1, 0, wc);
    check("div_gap", wc, 2);
    @(negedge clk);
    check("final_empty", 32'(fifo_empty), 1);
    check("no_bad_pop", bad_pop, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data bits per frame.
REQ-002 SHALL have parameter DIV_W, default 16: width of the baud divisor.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic rises on its positive edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port en, input, 1 bit: permits starting new frames.
REQ-006 SHALL have port baud_div, input, DIV_W bits: clocks per bit minus 1.
REQ-007 SHALL have port parity_odd, input, 1 bit: 1 selects odd parity, 0 selects even; used only with the parity build (REQ-030).
REQ-008 SHALL have port fifo_empty, input, 1 bit: empty flag of the TX FIFO.
REQ-009 SHALL have port fifo_dout, input, DATA_W bits: TX FIFO read data, valid the cycle after a pop.
REQ-010 SHALL have port pop_out, output, 1 bit: one-cycle pop strobe to the FIFO.
REQ-011 SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-012 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 SHALL have port tx_done, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-014 SHALL implement the states IDLE, LOAD, START, DATA, PARITY and STOP.
REQ-015 IDLE SHALL assert pop_out combinationally when en=1 and fifo_empty=0, and move to LOAD on the next edge.
REQ-016 LOAD SHALL last exactly 1 clock, capture fifo_dout into the shift register, latch baud_div, and move to START.
REQ-017 START SHALL drive tx=0 for baud_div+1 clocks; DATA SHALL shift DATA_W bits LSB first, each for baud_div+1 clocks.
REQ-018 In the parity build, PARITY SHALL follow DATA with one bit-time; STOP SHALL drive tx=1 for one bit-time.
REQ-019 tx_done SHALL pulse in the last clock of STOP, after which the state returns to IDLE.
REQ-020 Back-to-back frames: with the FIFO non-empty, the next START SHALL begin exactly 2 clocks after STOP ends (IDLE, LOAD), with tx high throughout.
REQ-021 baud_div=0 SHALL give 1-clock bits; changes to baud_div during a frame SHALL have no effect until the next LOAD.
REQ-022 Dropping en mid-frame SHALL let the current frame complete, with no further pop.
REQ-023 pop_out SHALL never assert outside IDLE, and never when fifo_empty=1.
REQ-024 The bit counter SHALL count 0..DATA_W-1 without wrap, and the baud counter SHALL reset to 0 at every bit boundary.

Reset
REQ-025 rst=0 SHALL immediately force state IDLE, tx=1, pop_out=0, busy=0, tx_done=0, and clear all counters and the shift register.
REQ-026 Reset asserted mid-frame SHALL abort the frame; the byte already popped is lost and no tx_done is produced.
REQ-027 Reset deassertion SHALL be the only condition needed to resume; the first pop SHALL occur on the first edge with en=1 and fifo_empty=0.

Configuration
REQ-028 The build SHALL be selected by macro UART_TX_PARITY_EN.
REQ-029 Without UART_TX_PARITY_EN, the frame SHALL be start + DATA_W data + 1 stop, PARITY SHALL be unreachable, and parity_odd SHALL be ignored.
REQ-030 With UART_TX_PARITY_EN, a parity bit SHALL be sent after the data: XOR of the data bits when parity_odd=0, its inverse when parity_odd=1; parity_odd SHALL be sampled at LOAD.

Structure
REQ-031 Package uart_pkg SHALL hold the state enum type, the DATA_W default, the IDLE_LEVEL=1 constant and the frame-length constants.
REQ-032 The baud counter and bit-tick generator SHALL be a sub-module, uart_baud_tick, with inputs clk, rst, load, div and output tick.
REQ-033 The engine SHALL connect directly to the existing fifo_uart read side: pop_out to pop_in, fifo_dout to dout, fifo_empty to empty.

Verification
REQ-034 Basic frame: baud_div=3, FIFO holds 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks, START to tx_done spanning 40 clocks, exactly one pop_out.
REQ-035 Parity build: 0xA5 with parity_odd=0 -> parity bit 0; with parity_odd=1 -> parity bit 1; frame spans 44 clocks.
REQ-036 Burst: 3 bytes pushed, baud_div=0 -> 3 frames, 2 idle-high clocks between each, 3 tx_done pulses, and fifo_empty=1 at the end with no 4th pop.
REQ-037 en drop: en=0 during the DATA of frame 1 with 2 bytes queued -> frame 1 completes, then tx stays 1 and no pop occurs until en=1.
REQ-038 Reset: rst=0 at bit 4 of a frame -> tx=1 and busy=0 within the same clock, no tx_done, and a fresh frame after release.
REQ-039 Divisor change: baud_div changed from 3 to 7 mid-frame -> the current frame keeps 4-clock bits and the next frame uses 8-clock bits.
